// File: rtl/mem_arbiter_if.sv
// Pipeline-side port bundle of the memory arbiter: the instruction-fetch
// port and the MEM-stage data request/response handshake.
interface mem_arbiter_if;
  logic [15:0] if_pc;
  logic [15:0] if_inst;
  logic        if_valid;
  logic        mem_en;
  logic        mem_op;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        ram_pause;

  // Arbiter side
  modport slave (
    input  if_pc, mem_en, mem_op, mem_addr, mem_wdata,
    output if_inst, if_valid, mem_rdata, mem_done, ram_pause
  );

  // Pipeline side
  modport master (
    output if_pc, mem_en, mem_op, mem_addr, mem_wdata,
    input  if_inst, if_valid, mem_rdata, mem_done, ram_pause
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares SRAM1, SRAM2 and the UART between instruction fetch and the
// MEM-stage data port. Data accesses run a small sequencer whose strobes
// are all registered from the next-state value so they never glitch;
// SRAM2 falls back to fetch mode whenever it is not serving data.
module mem_arbiter (
  input  logic        clk_50MHz,
  input  logic        rst,
  mem_arbiter_if.slave cpu,
  inout  wire  [15:0] sram1_data,
  output logic [17:0] sram1_addr,
  output logic        sram1_en,
  output logic        sram1_oe,
  output logic        sram1_we,
  inout  wire  [15:0] sram2_data,
  output logic [17:0] sram2_addr,
  output logic        sram2_en,
  output logic        sram2_oe,
  output logic        sram2_we,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        rdn,
  output logic        wrn
);

  typedef enum logic [3:0] {
    IDLE, RD, WSETUP, WPULSE, WHOLD, RXWAIT, URD0, URD1, TXWAIT, DONE
  } state_t;

  typedef enum logic [1:0] {T_SRAM1, T_SRAM2, T_UDATA, T_USTAT} tgt_t;

  localparam logic [17:0] UART_DATA_ADDR = 18'h0BF00;
  localparam logic [17:0] UART_STAT_ADDR = 18'h0BF01;
  localparam logic [17:0] SRAM2_LIMIT    = 18'h08000;

  state_t      state_q, state_d;
  tgt_t        tgt_q, tgt_d, req_tgt;
  logic [17:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        done_q, fetch_q, drv1_q, drv2_q;
  logic        en1_q, oe1_q, we1_q, en2_q, oe2_q, we2_q, rdn_q, wrn_q;
  logic        wr_d, s1_d, s2_d, ud_d, s2_data_d;

  // Decode the incoming data address into a target
  always_comb begin
    if (cpu.mem_addr == UART_DATA_ADDR)      req_tgt = T_UDATA;
    else if (cpu.mem_addr == UART_STAT_ADDR) req_tgt = T_USTAT;
    else if (cpu.mem_addr < SRAM2_LIMIT)     req_tgt = T_SRAM2;
    else                                     req_tgt = T_SRAM1;
  end

  // Next-state logic; the target is only re-latched when IDLE accepts a request
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (cpu.mem_en) begin
          tgt_d = req_tgt;
          if (cpu.mem_op)              state_d = WSETUP;
          else if (req_tgt == T_USTAT) state_d = DONE;
          else if (req_tgt == T_UDATA) state_d = RXWAIT;
          else                         state_d = RD;
        end
      end
      RD:     state_d = DONE;
      WSETUP: state_d = WPULSE;
      WPULSE: state_d = WHOLD;
      WHOLD:  state_d = (tgt_q == T_UDATA) ? TXWAIT : DONE;
      TXWAIT: if (tbre && tsre) state_d = DONE;
      RXWAIT: if (data_ready) state_d = URD0;
      URD0:   state_d = URD1;
      URD1:   state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe intent for the upcoming cycle, derived from next state and target
  always_comb begin
    wr_d      = (state_d == WSETUP) || (state_d == WPULSE) || (state_d == WHOLD);
    s1_d      = (tgt_d == T_SRAM1);
    s2_d      = (tgt_d == T_SRAM2);
    ud_d      = (tgt_d == T_UDATA);
    s2_data_d = s2_d && (wr_d || (state_d == RD));
  end

  // Sequencer state, registered strobes, completion pulse and read result
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= T_SRAM1;
      en1_q   <= 1'b1;
      oe1_q   <= 1'b1;
      we1_q   <= 1'b1;
      en2_q   <= 1'b0;
      oe2_q   <= 1'b0;
      we2_q   <= 1'b1;
      fetch_q <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      drv1_q  <= 1'b0;
      drv2_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      en1_q   <= ~(s1_d && (wr_d || (state_d == RD)));
      oe1_q   <= ~(s1_d && (state_d == RD));
      we1_q   <= ~(s1_d && (state_d == WPULSE));
      en2_q   <= 1'b0;
      oe2_q   <= s2_data_d && (state_d != RD);
      we2_q   <= ~(s2_data_d && (state_d == WPULSE));
      fetch_q <= ~s2_data_d;
      rdn_q   <= ~((state_d == URD0) || (state_d == URD1));
      wrn_q   <= ~(ud_d && (state_d == WPULSE));
      drv1_q  <= wr_d && (s1_d || ud_d);
      drv2_q  <= wr_d && s2_d;
      done_q  <= (state_d == DONE);
      if ((state_q == IDLE) && cpu.mem_en && !cpu.mem_op && (req_tgt == T_USTAT))
        rdata_q <= {14'b0, data_ready, tbre & tsre};
      else if (state_q == RD)
        rdata_q <= (tgt_q == T_SRAM2) ? sram2_data : sram1_data;
      else if (state_q == URD1)
        rdata_q <= sram1_data;
    end
  end

  // Request address and write data, captured when IDLE accepts a request
  always_ff @(posedge clk_50MHz) begin
    if ((state_q == IDLE) && cpu.mem_en) begin
      addr_q  <= cpu.mem_addr;
      wdata_q <= cpu.mem_wdata;
    end
  end

  assign sram1_addr = addr_q;
  assign sram2_addr = fetch_q ? {2'b00, cpu.if_pc} : addr_q;
  assign sram1_en   = en1_q;
  assign sram1_oe   = oe1_q;
  assign sram1_we   = we1_q;
  assign sram2_en   = en2_q;
  assign sram2_oe   = oe2_q;
  assign sram2_we   = we2_q;
  assign rdn        = rdn_q;
  assign wrn        = wrn_q;

  assign sram1_data = drv1_q ? wdata_q : 16'hzzzz;
  assign sram2_data = drv2_q ? wdata_q : 16'hzzzz;

  assign cpu.if_inst   = sram2_data;
  assign cpu.if_valid  = fetch_q;
  assign cpu.mem_rdata = rdata_q;
  assign cpu.mem_done  = done_q;
  assign cpu.ram_pause = cpu.mem_en & ~done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requests push their expected completion
// latency and read data; a monitor pops and compares on every mem_done.
module tb_mem_arbiter;
  logic clk_50MHz = 1'b0;
  logic rst;
  always #10 clk_50MHz = ~clk_50MHz;

  mem_arbiter_if cpu();

  wire  [15:0] sram1_data;
  wire  [15:0] sram2_data;
  logic [17:0] sram1_addr, sram2_addr;
  logic        sram1_en, sram1_oe, sram1_we;
  logic        sram2_en, sram2_oe, sram2_we;
  logic        data_ready, tbre, tsre, rdn, wrn;

  mem_arbiter dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .cpu       (cpu.slave),
    .sram1_data(sram1_data),
    .sram1_addr(sram1_addr),
    .sram1_en  (sram1_en),
    .sram1_oe  (sram1_oe),
    .sram1_we  (sram1_we),
    .sram2_data(sram2_data),
    .sram2_addr(sram2_addr),
    .sram2_en  (sram2_en),
    .sram2_oe  (sram2_oe),
    .sram2_we  (sram2_we),
    .data_ready(data_ready),
    .tbre      (tbre),
    .tsre      (tsre),
    .rdn       (rdn),
    .wrn       (wrn)
  );

  // SRAM / UART models
  logic [15:0] mem1 [1024];
  logic [15:0] mem2 [1024];
  logic [15:0] uart_rx, uart_tx;
  logic        tb_drv1, tb_drv2;
  logic [15:0] tb_v1, tb_v2;

  always_comb begin
    tb_drv1 = (!sram1_en && !sram1_oe) || !rdn;
    tb_v1   = !rdn ? uart_rx : mem1[sram1_addr[9:0]];
    tb_drv2 = !sram2_en && !sram2_oe;
    tb_v2   = mem2[sram2_addr[9:0]];
  end
  assign sram1_data = tb_drv1 ? tb_v1 : 16'hzzzz;
  assign sram2_data = tb_drv2 ? tb_v2 : 16'hzzzz;

  int          cyc = 0;
  int          t_start = 0;
  int          we1_cnt, we1_rel, wrn_cnt, rdn_cnt, rel;
  logic [31:0] ifv_mask;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    int          lat;
    logic [15:0] rdata;
    bit          chk;
    int          start;
  } exp_t;
  exp_t expq[$];
  exp_t m_e;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  // Memory writes and strobe bookkeeping, sampled mid-cycle
  always @(negedge clk_50MHz) begin
    if (!sram1_en && !sram1_we) mem1[sram1_addr[9:0]] = sram1_data;
    if (!sram2_en && !sram2_we) mem2[sram2_addr[9:0]] = sram2_data;
    if (!wrn) begin uart_tx = sram1_data; wrn_cnt++; end
    if (!rdn) rdn_cnt++;
    if (!sram1_we) begin we1_cnt++; we1_rel = cyc - t_start; end
    rel = cyc - t_start;
    if (!cpu.if_valid && rel >= 0 && rel < 32) ifv_mask[rel] = 1'b1;
  end

  // Scoreboard monitor: every completion must match the oldest expectation
  always @(negedge clk_50MHz) begin
    if (cpu.mem_done) begin
      if (expq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        m_e = expq.pop_front();
        vectors++;
        if (cyc - m_e.start != m_e.lat) begin
          miscompares++;
          $display("FAIL done_latency got %0d expected %0d", cyc - m_e.start, m_e.lat);
        end
        if (m_e.chk) begin
          vectors++;
          if (cpu.mem_rdata !== m_e.rdata) begin
            miscompares++;
            $display("FAIL mem_rdata got %h expected %h", cpu.mem_rdata, m_e.rdata);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {sram1_en, sram1_oe, sram1_we, rdn, wrn, sram2_en, sram2_oe, sram2_we};
  endfunction

  task automatic clear_counts();
    t_start  = cyc;
    we1_cnt  = 0;
    we1_rel  = -1;
    wrn_cnt  = 0;
    rdn_cnt  = 0;
    ifv_mask = 32'h0;
  endtask

  // Issue one request at the current negedge and hold it until mem_done
  task automatic do_req(input logic op, input logic [17:0] addr, input logic [15:0] wd,
                        input logic [15:0] er, input int lat, input bit chk, input bit chk_pause);
    exp_t e;
    bit   seen;
    e.lat = lat; e.rdata = er; e.chk = chk; e.start = cyc;
    expq.push_back(e);
    clear_counts();
    cpu.mem_en = 1'b1; cpu.mem_op = op; cpu.mem_addr = addr; cpu.mem_wdata = wd;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_50MHz);
      if (cpu.mem_done) seen = 1'b1;
      else if (chk_pause) check("ram_pause_busy", {31'b0, cpu.ram_pause}, 32'd1);
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout addr %h got no mem_done expected one", addr);
      if (expq.size() > 0) void'(expq.pop_back());
    end
    if (chk_pause) check("ram_pause_done", {31'b0, cpu.ram_pause}, 32'd0);
    cpu.mem_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin mem1[i] = 16'h0; mem2[i] = 16'h0; end
    mem2[3] = 16'h4A21;
    uart_rx = 16'h0055; uart_tx = 16'h0;
    rst = 1'b1;
    cpu.if_pc = 16'h0003; cpu.mem_en = 1'b0; cpu.mem_op = 1'b0;
    cpu.mem_addr = 18'h0; cpu.mem_wdata = 16'h0;
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
    clear_counts();
    repeat (3) @(negedge clk_50MHz);
    rst = 1'b0;
    @(negedge clk_50MHz);

    // Reset state and idle fetch
    check("reset_strobes", {24'b0, strobes()}, 32'h0000_00F9);
    check("reset_if_valid", {31'b0, cpu.if_valid}, 32'd1);
    check("reset_if_inst", {16'b0, cpu.if_inst}, 32'h4A21);
    check("reset_rdata", {16'b0, cpu.mem_rdata}, 32'h0);
    check("reset_done", {31'b0, cpu.mem_done}, 32'd0);

    // SRAM1 write then read back
    @(negedge clk_50MHz);
    do_req(1'b1, 18'h10000, 16'hBEEF, 16'h0, 4, 1'b0, 1'b0);
    check("s1_we_pulses", we1_cnt, 32'd1);
    check("s1_we_cycle", we1_rel, 32'd2);
    check("s1_mem_content", {16'b0, mem1[0]}, 32'hBEEF);
    @(negedge clk_50MHz);
    do_req(1'b0, 18'h10000, 16'h0, 16'hBEEF, 2, 1'b1, 1'b0);

    // SRAM2 write steals fetch for three cycles; fetch then sees new data
    @(negedge clk_50MHz);
    do_req(1'b1, 18'h00010, 16'h1234, 16'h0, 4, 1'b0, 1'b0);
    check("s2_wr_if_valid_gap", ifv_mask, 32'h0000_000E);
    cpu.if_pc = 16'h0010;
    @(negedge clk_50MHz);
    check("fetch_after_write", {16'b0, cpu.if_inst}, 32'h1234);
    check("fetch_valid", {31'b0, cpu.if_valid}, 32'd1);

    // SRAM2 data read: one-cycle fetch gap
    @(negedge clk_50MHz);
    do_req(1'b0, 18'h00010, 16'h0, 16'h1234, 2, 1'b1, 1'b0);
    check("s2_rd_if_valid_gap", ifv_mask, 32'h0000_0002);

    // UART write with transmitter busy through cycle 7
    @(negedge clk_50MHz);
    tbre = 1'b0;
    fork
      begin repeat (8) @(negedge clk_50MHz); tbre = 1'b1; end
    join_none
    do_req(1'b1, 18'h0BF00, 16'h0041, 16'h0, 9, 1'b0, 1'b0);
    check("uart_wrn_pulses", wrn_cnt, 32'd1);
    check("uart_tx_data", {16'b0, uart_tx}, 32'h0041);
    check("uart_no_sram1_we", we1_cnt, 32'd0);

    // Status read
    @(negedge clk_50MHz);
    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1;
    do_req(1'b0, 18'h0BF01, 16'h0, 16'h0003, 1, 1'b1, 1'b0);

    // UART read: data_ready rises in cycle 3
    @(negedge clk_50MHz);
    data_ready = 1'b0;
    fork
      begin repeat (3) @(negedge clk_50MHz); data_ready = 1'b1; end
    join_none
    do_req(1'b0, 18'h0BF00, 16'h0, 16'h0055, 6, 1'b1, 1'b1);
    check("uart_rdn_cycles", rdn_cnt, 32'd2);
    data_ready = 1'b0;

    // Write to the status address does nothing but still takes four cycles
    @(negedge clk_50MHz);
    do_req(1'b1, 18'h0BF01, 16'h5A5A, 16'h0, 4, 1'b0, 1'b0);
    check("stat_wr_no_wrn", wrn_cnt, 32'd0);
    check("stat_wr_no_we", we1_cnt, 32'd0);

    // Reset in the middle of an SRAM1 write pulse
    @(negedge clk_50MHz);
    clear_counts();
    cpu.mem_en = 1'b1; cpu.mem_op = 1'b1; cpu.mem_addr = 18'h10005; cpu.mem_wdata = 16'hAAAA;
    repeat (2) @(negedge clk_50MHz);
    check("mid_rst_in_pulse", {31'b0, sram1_we}, 32'd0);
    #2 rst = 1'b1;
    #1 check("mid_rst_we_release", {31'b0, sram1_we}, 32'd1);
    cpu.mem_en = 1'b0;
    @(negedge clk_50MHz);
    check("mid_rst_strobes", {24'b0, strobes()}, 32'h0000_00F9);
    check("mid_rst_rdata", {16'b0, cpu.mem_rdata}, 32'h0);
    repeat (2) @(negedge clk_50MHz);
    rst = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    check("mid_rst_single_pulse", we1_cnt, 32'd1);
    check("mid_rst_idle_strobes", {24'b0, strobes()}, 32'h0000_00F9);

    // Controller is back in IDLE and serves a read normally
    @(negedge clk_50MHz);
    do_req(1'b0, 18'h10000, 16'h0, 16'hBEEF, 2, 1'b1, 1'b0);

    repeat (2) @(negedge clk_50MHz);
    check("scoreboard_drained", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
